// File: rtl/rs_seg_addr_seq.sv
// Segment address sequencer: expands a segment base address into SEG_LEN
// consecutive symbol addresses with valid/ready on both sides and a one-entry pending slot.
module rs_seg_addr_seq #(
    parameter int unsigned SEG_LEN = 32,
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned CNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              base_valid,
    output logic              base_ready,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              rd_last,
    output logic              busy,
    output logic [CNT_W-1:0]  seg_count,
    output logic              align_err
);

    localparam int unsigned OFF_W = $clog2(SEG_LEN);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(SEG_LEN - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   active_q, active_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [ADDR_W-1:0]   pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]    seg_count_q, seg_count_d;
    logic                align_err_q, align_err_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                rd_last_q, rd_last_d;

    logic base_xfer;
    logic beat;
    logic misaligned;

    assign base_ready = !pend_valid_q;
    assign base_xfer  = base_valid && base_ready;
    assign beat       = rd_valid_q && rd_ready;
    assign misaligned = (base_addr[OFF_W-1:0] != '0);

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        off_d        = off_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        seg_count_d  = seg_count_q;
        align_err_d  = align_err_q || (base_xfer && misaligned);

        case (state_q)
            IDLE: begin
                if (base_xfer) begin
                    active_d = base_addr;
                    off_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (beat && (off_q == OFF_LAST)) begin
                    seg_count_d = seg_count_q + CNT_W'(1);
                    // Pending base first; otherwise a base arriving now starts with no bubble
                    if (pend_valid_q) begin
                        active_d     = pend_q;
                        off_d        = '0;
                        pend_valid_d = 1'b0;
                    end else if (base_xfer) begin
                        active_d = base_addr;
                        off_d    = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        off_d = off_q + OFF_W'(1);
                    end
                    if (base_xfer) begin
                        pend_d       = base_addr;
                        pend_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state so a stall leaves them untouched
        rd_addr_d  = active_d + ADDR_W'(off_d);
        rd_valid_d = (state_d == RUN);
        rd_last_d  = rd_valid_d && (off_d == OFF_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            active_q     <= '0;
            off_q        <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            seg_count_q  <= '0;
            align_err_q  <= 1'b0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            off_q        <= off_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            seg_count_q  <= seg_count_d;
            align_err_q  <= align_err_d;
            rd_addr_q    <= rd_addr_d;
            rd_valid_q   <= rd_valid_d;
            rd_last_q    <= rd_last_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_last   = rd_last_q;
    assign busy      = (state_q == RUN) || pend_valid_q;
    assign seg_count = seg_count_q;
    assign align_err = align_err_q;

endmodule
